// File: rtl/uart_rx_ovs.sv
// uart_rx_ovs: 16x-oversampling UART receiver, 8N1 by default.
// Optional even-parity checking (8E1) is compiled in with MMUART_RX_PARITY_EN,
// which adds the PARITY state and the rx_parity_err output.
module uart_rx_ovs #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        uart_rx,
    input  logic [15:0] divisor,
    output logic [7:0]  rx_data,
    output logic        rx_done,
`ifdef MMUART_RX_PARITY_EN
    output logic        rx_parity_err,
`endif
    output logic        rx_frame_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef MMUART_RX_PARITY_EN
        S_PARITY,
`endif
        S_STOP,
        S_WAIT_HIGH
    } state_t;

    logic [15:0]            cnt_q, cnt_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    state_t                 state_q, state_d;
    logic [3:0]             c16_q, c16_d;
    logic [3:0]             bc_q, bc_d;
    logic [7:0]             sh_q, sh_d;
    logic [7:0]             rx_data_q, rx_data_d;
    logic                   rx_done_q, rx_done_d;
    logic                   rx_frame_err_q, rx_frame_err_d;
`ifdef MMUART_RX_PARITY_EN
    logic                   pbad_q, pbad_d;
    logic                   rx_parity_err_q, rx_parity_err_d;
`endif
    logic                   tick;
    logic                   rxs;

    assign tick         = (cnt_q == 16'd0);
    assign rxs          = sync_q[SYNC_STAGES-1];
    assign rx_data      = rx_data_q;
    assign rx_done      = rx_done_q;
    assign rx_frame_err = rx_frame_err_q;
`ifdef MMUART_RX_PARITY_EN
    assign rx_parity_err = rx_parity_err_q;
`endif

    // Next-state logic: tick divider, synchroniser shift and the frame FSM
    // (FSM only advances on tick cycles; pulses default low every cycle).
    always_comb begin
        cnt_d          = tick ? (divisor - 16'd1) : (cnt_q - 16'd1);
        sync_d         = {sync_q[SYNC_STAGES-2:0], uart_rx};
        state_d        = state_q;
        c16_d          = c16_q;
        bc_d           = bc_q;
        sh_d           = sh_q;
        rx_data_d      = rx_data_q;
        rx_done_d      = 1'b0;
        rx_frame_err_d = 1'b0;
`ifdef MMUART_RX_PARITY_EN
        pbad_d          = pbad_q;
        rx_parity_err_d = 1'b0;
`endif
        if (tick) begin
            case (state_q)
                S_IDLE: begin
                    if (!rxs) begin
                        c16_d   = 4'd0;
                        state_d = S_START;
                    end
                end
                S_START: begin
                    // Mid-start-bit check: a line already back high was a glitch.
                    if (c16_q == 4'd7) begin
                        if (rxs) begin
                            state_d = S_IDLE;
                        end else begin
                            c16_d   = 4'd0;
                            bc_d    = 4'd0;
                            state_d = S_DATA;
                        end
                    end else begin
                        c16_d = c16_q + 4'd1;
                    end
                end
                S_DATA: begin
                    c16_d = c16_q + 4'd1;
                    if (c16_q == 4'd15) begin
                        sh_d = {rxs, sh_q[7:1]};
                        bc_d = bc_q + 4'd1;
                        if (bc_q == 4'd7) begin
`ifdef MMUART_RX_PARITY_EN
                            state_d = S_PARITY;
`else
                            state_d = S_STOP;
`endif
                        end
                    end
                end
`ifdef MMUART_RX_PARITY_EN
                S_PARITY: begin
                    c16_d = c16_q + 4'd1;
                    if (c16_q == 4'd15) begin
                        // Even parity: data ones plus parity bit must be even.
                        pbad_d  = (^sh_q) ^ rxs;
                        state_d = S_STOP;
                    end
                end
`endif
                S_STOP: begin
                    c16_d = c16_q + 4'd1;
                    if (c16_q == 4'd15) begin
                        if (rxs) begin
`ifdef MMUART_RX_PARITY_EN
                            if (pbad_q) begin
                                rx_parity_err_d = 1'b1;
                            end else begin
                                rx_data_d = sh_q;
                                rx_done_d = 1'b1;
                            end
`else
                            rx_data_d = sh_q;
                            rx_done_d = 1'b1;
`endif
                            state_d = S_IDLE;
                        end else begin
                            // Framing error outranks parity; wait for line release.
                            rx_frame_err_d = 1'b1;
                            state_d        = S_WAIT_HIGH;
                        end
                    end
                end
                S_WAIT_HIGH: begin
                    if (rxs) state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            cnt_q          <= divisor - 16'd1;
            sync_q         <= '1;
            state_q        <= S_IDLE;
            c16_q          <= 4'd0;
            bc_q           <= 4'd0;
            sh_q           <= 8'h00;
            rx_data_q      <= 8'h00;
            rx_done_q      <= 1'b0;
            rx_frame_err_q <= 1'b0;
`ifdef MMUART_RX_PARITY_EN
            pbad_q          <= 1'b0;
            rx_parity_err_q <= 1'b0;
`endif
        end else begin
            cnt_q          <= cnt_d;
            sync_q         <= sync_d;
            state_q        <= state_d;
            c16_q          <= c16_d;
            bc_q           <= bc_d;
            sh_q           <= sh_d;
            rx_data_q      <= rx_data_d;
            rx_done_q      <= rx_done_d;
            rx_frame_err_q <= rx_frame_err_d;
`ifdef MMUART_RX_PARITY_EN
            pbad_q          <= pbad_d;
            rx_parity_err_q <= rx_parity_err_d;
`endif
        end
    end

endmodule

// File: tb/tb_uart_rx_ovs.sv
// Scoreboard bench for uart_rx_ovs: stimulus pushes expected events, a
// negedge monitor pops and checks them whenever the DUT pulses an output.
module tb_uart_rx_ovs;

    localparam int SYNC = 2;
    localparam int BIT  = 64;   // divisor 4 -> 64 clocks per bit

    localparam logic [1:0] EV_DONE  = 2'd0;
    localparam logic [1:0] EV_FRAME = 2'd1;
    localparam logic [1:0] EV_PAR   = 2'd2;

    typedef struct {
        logic [1:0] kind;
        logic [7:0] data;
    } ev_t;

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic        uart_rx = 1'b1;
    logic [15:0] divisor = 16'd4;
    logic [7:0]  rx_data;
    logic        rx_done;
    logic        rx_frame_err;
    logic        par_err;

    ev_t         exp_q[$];
    int          tests = 0;
    int          fails = 0;
    logic [7:0]  last_good = 8'h00;
    logic [7:0]  prev_data = 8'h00;

    always #5 sys_clk = ~sys_clk;

`ifdef MMUART_RX_PARITY_EN
    uart_rx_ovs #(.SYNC_STAGES(SYNC)) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .uart_rx(uart_rx),
        .divisor(divisor), .rx_data(rx_data), .rx_done(rx_done),
        .rx_parity_err(par_err), .rx_frame_err(rx_frame_err));
`else
    assign par_err = 1'b0;
    uart_rx_ovs #(.SYNC_STAGES(SYNC)) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .uart_rx(uart_rx),
        .divisor(divisor), .rx_data(rx_data), .rx_done(rx_done),
        .rx_frame_err(rx_frame_err));
`endif

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [1:0] k, input logic [7:0] d);
        ev_t e;
        e.kind = k;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic bit_out(input logic b);
        uart_rx = b;
        repeat (BIT) @(posedge sys_clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_b,
                              input logic with_par, input logic par_b);
        bit_out(1'b0);
        for (int i = 0; i < 8; i++) bit_out(d[i]);
        if (with_par) bit_out(par_b);
        bit_out(stop_b);
    endtask

    task automatic idle_bits(input int n);
        uart_rx = 1'b1;
        repeat (n * BIT) @(posedge sys_clk);
        #1;
    endtask

    // Monitor: pop and compare on every output pulse; rx_data may only move with rx_done.
    always @(negedge sys_clk) begin
        ev_t e;
        if (!sys_rst) begin
            if ((int'(rx_done) + int'(rx_frame_err) + int'(par_err)) > 1)
                chk("pulse_exclusive", {29'd0, rx_done, rx_frame_err, par_err}, 32'd0);
            if (rx_data != prev_data)
                chk("rx_data_moves_only_on_done", {31'd0, rx_done}, 32'd1);
            if (rx_done || rx_frame_err || par_err) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_pulse", {29'd0, rx_done, rx_frame_err, par_err}, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("event_kind", {30'd0, rx_frame_err ? EV_FRAME : (par_err ? EV_PAR : EV_DONE)},
                        {30'd0, e.kind});
                    if (e.kind == EV_DONE) begin
                        chk("rx_data", {24'd0, rx_data}, {24'd0, e.data});
                        last_good = e.data;
                    end else begin
                        chk("rx_data_held_on_err", {24'd0, rx_data}, {24'd0, last_good});
                    end
                end
            end
        end
        prev_data = rx_data;
    end

    initial begin
        #(60000 * 10);
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        repeat (5) @(posedge sys_clk);
        #1;
        chk("reset_rx_data", {24'd0, rx_data}, 32'h00);
        chk("reset_rx_done", {31'd0, rx_done}, 32'd0);
        chk("reset_frame_err", {31'd0, rx_frame_err}, 32'd0);
        chk("reset_parity_err", {31'd0, par_err}, 32'd0);
        sys_rst = 1'b0;
        idle_bits(2);

        // 0xA5 with latency measurement from the start edge
        push(EV_DONE, 8'hA5);
        cyc = 0;
        fork
            send_frame(8'hA5, 1'b1, 1'b0, 1'b0);
            begin
                while (!rx_done && cyc < 2000) begin
                    @(negedge sys_clk);
                    cyc++;
                end
            end
        join
        chk("latency_a5_in_window",
            {31'd0, (cyc >= 608 + SYNC) && (cyc <= 616 + SYNC)}, 32'd1);
        idle_bits(2);

        // back-to-back 0x00, 0xFF
        push(EV_DONE, 8'h00);
        push(EV_DONE, 8'hFF);
        send_frame(8'h00, 1'b1, 1'b0, 1'b0);
        send_frame(8'hFF, 1'b1, 1'b0, 1'b0);
        idle_bits(2);

        // 20-clock glitch is rejected, then 0x3C
        uart_rx = 1'b0;
        repeat (20) @(posedge sys_clk);
        #1;
        idle_bits(3);
        push(EV_DONE, 8'h3C);
        send_frame(8'h3C, 1'b1, 1'b0, 1'b0);
        idle_bits(2);

        // 0x55 with low stop bit, line held low (break), then 0x81
        push(EV_FRAME, 8'h00);
        send_frame(8'h55, 1'b0, 1'b0, 1'b0);
        uart_rx = 1'b0;
        repeat (3 * BIT) @(posedge sys_clk);
        #1;
        idle_bits(2);
        push(EV_DONE, 8'h81);
        send_frame(8'h81, 1'b1, 1'b0, 1'b0);
        idle_bits(2);

        // reset in the middle of bit 4 of a frame, then 0xC3
        bit_out(1'b0);
        for (int i = 0; i < 4; i++) bit_out(i[0]);
        uart_rx = 1'b1;
        repeat (20) @(posedge sys_clk);
        #1;
        sys_rst = 1'b1;
        repeat (4) @(posedge sys_clk);
        #1;
        chk("midframe_reset_rx_data", {24'd0, rx_data}, 32'h00);
        sys_rst = 1'b0;
        idle_bits(3);
        push(EV_DONE, 8'hC3);
        send_frame(8'hC3, 1'b1, 1'b0, 1'b0);
        idle_bits(2);
        chk("rx_data_holds_c3", {24'd0, rx_data}, 32'hC3);

`ifdef MMUART_RX_PARITY_EN
        push(EV_PAR, 8'h00);
        send_frame(8'h07, 1'b1, 1'b1, 1'b0);
        idle_bits(2);
        push(EV_DONE, 8'h07);
        send_frame(8'h07, 1'b1, 1'b1, 1'b1);
        idle_bits(2);
        chk("rx_data_holds_07", {24'd0, rx_data}, 32'h07);
`endif

        idle_bits(4);
        chk("scoreboard_empty", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
